// File: rtl/button_event_arbiter.sv
// ============================================================================
//  Module      : button_event_arbiter
//  Description : Per-button PRESS/RELEASE/HOLD/REPEAT detection with 1-deep
//                pending slots drained round-robin into one valid/ready stream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_event_arbiter #(
    parameter  int N_BTN         = 4,
    parameter  int HOLD_CYCLES   = 1000,
    parameter  int REPEAT_CYCLES = 250,
    localparam int IDW           = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_state,
    input  logic [N_BTN-1:0] btn_down,
    input  logic [N_BTN-1:0] btn_up,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDW-1:0]   ev_id,
    output logic [1:0]       ev_type,
    output logic             ev_drop
);

    localparam int c_TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [1:0] c_EV_PRESS   = 2'b00;
    localparam logic [1:0] c_EV_RELEASE = 2'b01;
    localparam logic [1:0] c_EV_HOLD    = 2'b10;
    localparam logic [1:0] c_EV_REPEAT  = 2'b11;

    // The press cycle itself counts toward the hold time, so PRESSED ends one
    // count early; each repeat period is a full REPEAT_CYCLES inside HELD.
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST   = c_TMR_W'(HOLD_CYCLES - 2);
    localparam logic [c_TMR_W-1:0] c_REPEAT_LAST = c_TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [IDW-1:0]     c_LAST_ID     = IDW'(N_BTN - 1);

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } btn_fsm_t;

    logic [N_BTN-1:0]      w_slot_full;
    logic [N_BTN-1:0][1:0] w_slot_type;
    logic [N_BTN-1:0]      w_drain;
    logic [N_BTN-1:0]      w_drop;

    logic                  w_advance;
    logic                  w_pick_found;
    logic [IDW-1:0]        w_pick_idx;
    int                    w_scan_idx;

    logic                  r_ev_valid;
    logic [IDW-1:0]        r_ev_id;
    logic [1:0]            r_ev_type;
    logic                  r_ev_drop;
    logic [IDW-1:0]        r_rr;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_fsm_t             r_state;
        btn_fsm_t             w_state_nxt;
        logic [c_TMR_W-1:0]   r_timer;
        logic [c_TMR_W-1:0]   w_timer_nxt;
        logic                 w_raise;
        logic [1:0]           w_raise_type;
        logic                 r_full;
        logic [1:0]           r_type;

        always_comb begin
            w_state_nxt  = r_state;
            w_timer_nxt  = r_timer;
            w_raise      = 1'b0;
            w_raise_type = c_EV_PRESS;
            if (btn_up[gi]) begin
                w_state_nxt  = S_UP;
                w_timer_nxt  = '0;
                w_raise      = 1'b1;
                w_raise_type = c_EV_RELEASE;
            end else if (btn_down[gi]) begin
                w_state_nxt  = S_PRESSED;
                w_timer_nxt  = '0;
                w_raise      = 1'b1;
                w_raise_type = c_EV_PRESS;
            end else begin
                case (r_state)
                    S_PRESSED: begin
                        if (!btn_state[gi]) begin
                            w_state_nxt = S_UP;
                            w_timer_nxt = '0;
                        end else if (r_timer == c_HOLD_LAST) begin
                            w_state_nxt  = S_HELD;
                            w_timer_nxt  = '0;
                            w_raise      = 1'b1;
                            w_raise_type = c_EV_HOLD;
                        end else begin
                            w_timer_nxt = r_timer + c_TMR_W'(1);
                        end
                    end
                    S_HELD: begin
                        if (!btn_state[gi]) begin
                            w_state_nxt = S_UP;
                            w_timer_nxt = '0;
                        end else if (r_timer == c_REPEAT_LAST) begin
                            w_timer_nxt  = '0;
                            w_raise      = 1'b1;
                            w_raise_type = c_EV_REPEAT;
                        end else begin
                            w_timer_nxt = r_timer + c_TMR_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = S_UP;
                        w_timer_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_UP;
                r_timer <= '0;
                r_full  <= 1'b0;
                r_type  <= c_EV_PRESS;
            end else begin
                r_state <= w_state_nxt;
                r_timer <= w_timer_nxt;
                // A slot being drained this cycle is free for the new event.
                if (w_drain[gi] || !r_full) begin
                    r_full <= w_raise;
                    r_type <= w_raise_type;
                end
            end
        end

        assign w_drain[gi]     = w_advance & w_pick_found & (w_pick_idx == IDW'(gi));
        assign w_drop[gi]      = r_full & ~w_drain[gi] & w_raise &
                                 ~((w_raise_type == c_EV_REPEAT) && (r_type == c_EV_REPEAT));
        assign w_slot_full[gi] = r_full;
        assign w_slot_type[gi] = r_type;
    end

    assign w_advance = ~r_ev_valid | ev_ready;

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = 0;
        for (int k = 0; k < N_BTN; k++) begin
            w_scan_idx = int'(r_rr) + k;
            if (w_scan_idx >= N_BTN) begin
                w_scan_idx = w_scan_idx - N_BTN;
            end
            if (!w_pick_found && w_slot_full[IDW'(w_scan_idx)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = IDW'(w_scan_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_valid <= 1'b0;
            r_ev_id    <= '0;
            r_ev_type  <= c_EV_PRESS;
            r_ev_drop  <= 1'b0;
            r_rr       <= '0;
        end else begin
            r_ev_drop <= |w_drop;
            if (w_advance) begin
                if (w_pick_found) begin
                    r_ev_valid <= 1'b1;
                    r_ev_id    <= w_pick_idx;
                    r_ev_type  <= w_slot_type[w_pick_idx];
                    r_rr       <= (w_pick_idx == c_LAST_ID) ? '0 : w_pick_idx + IDW'(1);
                end else begin
                    r_ev_valid <= 1'b0;
                end
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_id    = r_ev_id;
    assign ev_type  = r_ev_type;
    assign ev_drop  = r_ev_drop;

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
// ============================================================================
//  Module      : tb_button_event_arbiter
//  Description : Self-checking bench for button_event_arbiter with a
//                behavioural press-age / pending-event reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_event_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    localparam int T_PRESS = 0;
    localparam int T_REL   = 1;
    localparam int T_HOLD  = 2;
    localparam int T_REP   = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_state;
    logic [N-1:0] btn_down;
    logic [N-1:0] btn_up;
    logic         ev_ready;
    logic         ev_valid;
    logic [1:0]   ev_id;
    logic [1:0]   ev_type;
    logic         ev_drop;

    button_event_arbiter #(
        .N_BTN        (N),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_state(btn_state),
        .btn_down (btn_down),
        .btn_up   (btn_up),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .ev_type  (ev_type),
        .ev_drop  (ev_drop)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int drop_cnt = 0;

    // Model: age = cycles since the press (-1 when released), pend = queued type or -1.
    int age  [N];
    int pend [N];
    bit m_valid;
    bit m_drop;
    int m_id;
    int m_type;
    int m_rr;

    typedef struct {
        int c;
        int id;
        int typ;
    } acc_t;
    acc_t acc_q[$];

    task automatic model_step(input logic r, input logic [N-1:0] st, input logic [N-1:0] dn,
                              input logic [N-1:0] up, input logic rdy);
        int ev [N];
        int pick;
        bit adv;
        if (r) begin
            foreach (age[i]) begin
                age[i]  = -1;
                pend[i] = -1;
            end
            m_valid = 0; m_id = 0; m_type = 0; m_drop = 0; m_rr = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            ev[i] = -1;
            if (up[i]) begin
                ev[i] = T_REL; age[i] = -1;
            end else if (dn[i]) begin
                ev[i] = T_PRESS; age[i] = 0;
            end else if (age[i] >= 0) begin
                if (!st[i]) age[i] = -1;
                else begin
                    age[i]++;
                    if (age[i] == HOLD - 1) ev[i] = T_HOLD;
                    else if (age[i] > HOLD - 1 && (age[i] - (HOLD - 1)) % REP == 0) ev[i] = T_REP;
                end
            end
        end
        adv  = !m_valid || rdy;
        pick = -1;
        if (adv) begin
            for (int k = 0; k < N; k++)
                if (pick < 0 && pend[(m_rr + k) % N] >= 0) pick = (m_rr + k) % N;
        end
        if (pick >= 0) begin
            m_valid = 1; m_id = pick; m_type = pend[pick]; m_rr = (pick + 1) % N;
        end else if (adv) begin
            m_valid = 0;
        end
        m_drop = 0;
        for (int i = 0; i < N; i++) begin
            if (i == pick || pend[i] < 0) pend[i] = ev[i];
            else if (ev[i] >= 0 && !(ev[i] == T_REP && pend[i] == T_REP)) m_drop = 1;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] st, input logic [N-1:0] dn,
                        input logic [N-1:0] up, input logic rdy);
        if (!r && ev_valid === 1'b1 && rdy) acc_q.push_back('{cyc, int'(ev_id), int'(ev_type)});
        if (ev_drop === 1'b1) drop_cnt++;
        rst = r; btn_state = st; btn_down = dn; btn_up = up; ev_ready = rdy;
        model_step(r, st, dn, up, rdy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, '0, 1'b0);
        acc_q.delete();
        drop_cnt = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF, 4'hF, 4'h0, 1'b1);
            checks++;
            if (ev_valid !== 1'b0 || ev_drop !== 1'b0 || ev_id !== 2'd0 || ev_type !== 2'd0) begin
                failures++;
                $display("FAIL reset: valid=%b drop=%b id=%0d type=%0d, required all 0",
                         ev_valid, ev_drop, ev_id, ev_type);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            checks++;
            if (ev_valid !== 1'b0 || ev_drop !== 1'b0) begin
                failures++;
                $display("FAIL reset_after: valid=%b drop=%b, required 0 0", ev_valid, ev_drop);
            end
        end
    endtask

    task automatic test_single_press();
        int t0;
        int ec [5];
        int et [5];
        ec = '{2, 9, 13, 17, 19};
        et = '{T_PRESS, T_HOLD, T_REP, T_REP, T_REL};
        do_reset();
        t0 = cyc;
        step(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1);
        for (int k = 1; k <= 16; k++) step(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        checks++;
        if (acc_q.size() != 5) begin
            failures++;
            $display("FAIL single_press_count: got %0d events, required 5", acc_q.size());
        end
        for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].c - t0 != ec[i] || acc_q[i].id != 2 || acc_q[i].typ != et[i]) begin
                failures++;
                $display("FAIL single_press[%0d]: got cyc=+%0d id=%0d type=%0d, required cyc=+%0d id=2 type=%0d",
                         i, acc_q[i].c - t0, acc_q[i].id, acc_q[i].typ, ec[i], et[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int t0, t1, t2, t3;
        int ec  [9];
        int eid [9];
        do_reset();
        t0 = cyc;
        step(1'b0, 4'hF, 4'hF, 4'h0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        t1 = cyc;
        step(1'b0, 4'b1001, 4'b1001, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        t2 = cyc;
        step(1'b0, 4'b0010, 4'b0010, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        t3 = cyc;
        step(1'b0, 4'b1001, 4'b1001, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        ec  = '{t0 + 2, t0 + 3, t0 + 4, t0 + 5, t1 + 2, t1 + 3, t2 + 2, t3 + 2, t3 + 3};
        eid = '{0, 1, 2, 3, 0, 3, 1, 3, 0};
        checks++;
        if (acc_q.size() != 9) begin
            failures++;
            $display("FAIL rr_count: got %0d events, required 9", acc_q.size());
        end
        for (int i = 0; i < 9 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].c != ec[i] || acc_q[i].id != eid[i] || acc_q[i].typ != T_PRESS) begin
                failures++;
                $display("FAIL rr[%0d]: got cyc=%0d id=%0d type=%0d, required cyc=%0d id=%0d type=0",
                         i, acc_q[i].c, acc_q[i].id, acc_q[i].typ, ec[i], eid[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] v;
        do_reset();
        step(1'b0, 4'b0010, 4'b0010, 4'h0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_id !== 2'd1 || ev_type !== 2'b00) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b id=%0d type=%0d, required 1 1 0",
                         i, ev_valid, ev_id, ev_type);
            end
            v = (i == 1 || i == 3) ? 4'b0010 : 4'b0000;
            step(1'b0, v, v, 4'h0, 1'b0);
        end
        for (int k = 0; k < 5; k++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        checks++;
        if (drop_cnt != 1) begin
            failures++;
            $display("FAIL backpressure_drop: got %0d drop cycles, required 1", drop_cnt);
        end
        checks++;
        if (acc_q.size() != 2 || acc_q[0].id != 1 || acc_q[0].typ != T_PRESS ||
            acc_q[1].id != 1 || acc_q[1].typ != T_PRESS) begin
            failures++;
            $display("FAIL backpressure_events: got %0d events, required 2 PRESS on id 1", acc_q.size());
        end
    endtask

    task automatic test_coalesce();
        int t0;
        int nrep;
        do_reset();
        t0 = cyc;
        for (int k = 0; k <= 28; k++)
            step(1'b0, 4'b0010, (k == 0) ? 4'b0010 : 4'b0000, 4'h0, (k < 10 || k >= 25));
        step(1'b0, 4'h0, 4'h0, 4'b0010, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        nrep = 0;
        foreach (acc_q[i])
            if (acc_q[i].c >= t0 + 25 && acc_q[i].c <= t0 + 28 && acc_q[i].typ == T_REP && acc_q[i].id == 1)
                nrep++;
        checks++;
        if (nrep != 2) begin
            failures++;
            $display("FAIL coalesce_repeats: got %0d REPEATs drained, required 2", nrep);
        end
        checks++;
        if (drop_cnt != 0) begin
            failures++;
            $display("FAIL coalesce_drop: got %0d drop cycles, required 0", drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 4'b0001, 4'b0001, 4'h0, 1'b0);
        for (int k = 1; k <= 9; k++) step(1'b0, 4'b0001, 4'h0, 4'h0, 1'b0);
        checks++;
        if (ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: got valid=%b, required 1", ev_valid);
        end
        step(1'b1, 4'b0001, 4'h0, 4'h0, 1'b0);
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear: got valid=%b, required 0", ev_valid);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0001, 4'h0, 4'h0, 1'b1);
            checks++;
            if (ev_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet[%0d]: got valid=%b type=%0d, required valid 0", k, ev_valid, ev_type);
            end
        end
        step(1'b0, 4'b0001, 4'b0001, 4'h0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd0 || ev_type !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_repress: got valid=%b id=%0d type=%0d, required 1 0 0",
                     ev_valid, ev_id, ev_type);
        end
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_random();
        bit           held [N];
        logic [N-1:0] st, dn, up;
        logic         r, rdy;
        int           x;
        do_reset();
        foreach (held[i]) held[i] = 0;
        for (int n = 0; n < 2000; n++) begin
            st = '0; dn = '0; up = '0;
            for (int i = 0; i < N; i++) begin
                if (!held[i]) begin
                    if ($urandom_range(0, 19) == 0) begin
                        dn[i] = 1'b1; st[i] = 1'b1; held[i] = 1;
                    end else if ($urandom_range(0, 199) == 0) begin
                        up[i] = 1'b1;
                    end
                end else begin
                    x = $urandom_range(0, 99);
                    if (x < 4) begin
                        up[i] = 1'b1; held[i] = 0;
                        if ($urandom_range(0, 3) == 0) dn[i] = 1'b1;
                    end else if (x < 6) begin
                        held[i] = 0;
                    end else begin
                        st[i] = 1'b1;
                    end
                end
            end
            rdy = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 499) == 0);
            step(r, st, dn, up, rdy);
            checks++;
            if (ev_valid !== m_valid || ev_drop !== m_drop ||
                (m_valid && (ev_id !== 2'(m_id) || ev_type !== 2'(m_type)))) begin
                failures++;
                $display("FAIL random@%0d: got valid=%b id=%0d type=%0d drop=%b, required valid=%b id=%0d type=%0d drop=%b",
                         cyc, ev_valid, ev_id, ev_type, ev_drop, m_valid, m_id, m_type, m_drop);
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn_state = '0; btn_down = '0; btn_up = '0; ev_ready = 1'b0;
        #1;
        test_reset();
        test_single_press();
        test_round_robin();
        test_backpressure();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
